// File: rtl/cnt_share_arbiter.sv
// Shared-timer sequencer: grants one free-running up-counter to NREQ
// requesters in round-robin order, runs it to the winner's terminal count,
// then reports completion (done) or early release (abort) with the owner id.
module cnt_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int CNT_W = 16,
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*CNT_W-1:0] req_len,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic [CNT_W-1:0]      count,
    output logic                  done,
    output logic                  abort,
    output logic [IDX_W-1:0]      done_id
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t                       state;
    logic [IDX_W-1:0]             rr_ptr;
    logic [IDX_W-1:0]             owner;
    logic [CNT_W-1:0]             len;
    logic [IDX_W-1:0]             win;
    logic [NREQ-1:0][CNT_W-1:0]   lens;

    // Unpack the flat terminal-count bus into one lane per requester.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_lane
            assign lens[gi] = req_len[gi*CNT_W +: CNT_W];
        end
    endgenerate

    // Round-robin pick: first set request after rr_ptr, wrapping mod NREQ.
    // Scanning from the far end lets the nearest candidate overwrite the rest.
    always_comb begin
        int idx;
        win = rr_ptr;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (req[idx]) win = IDX_W'(idx);
        end
    end

    // Sequencer FSM with registered outputs; done/abort are single-cycle pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rr_ptr  <= IDX_W'(NREQ - 1);
            owner   <= '0;
            len     <= '0;
            count   <= '0;
            gnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            abort   <= 1'b0;
            done_id <= '0;
        end else begin
            done  <= 1'b0;
            abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        owner   <= win;
                        done_id <= win;
                        len     <= lens[win];
                        rr_ptr  <= win;
                        count   <= '0;
                        gnt     <= NREQ'(1) << win;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    // Losing the request wins over a same-cycle completion.
                    if (!req[owner]) begin
                        abort <= 1'b1;
                        gnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (count == len) begin
                        done  <= 1'b1;
                        gnt   <= '0;
                        busy  <= 1'b0;
                        state <= FIN;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                // Release gap so the finished requester can drop req.
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
